// File: rtl/logic_pattern_sequencer_pkg.sv
// Shared types and helpers for the AND/OR gate-unit stimulus sequencer.
package lps_pkg;

    localparam int ERR_STEP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // 2-bit binary to Gray: 0->00, 1->01, 2->11, 3->10
    function automatic logic [1:0] gray2(input logic [1:0] step);
        return step ^ (step >> 1);
    endfunction

endpackage

// File: rtl/logic_pattern_sequencer_dwell_timer.sv
// Load/count-down settle timer; expire_o marks the last cycle of the wait window.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            // a zero dwell still gets one settle cycle
            cnt_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/logic_pattern_sequencer.sv
// Steps the gate-unit inputs through a Gray pattern, dwells, then checks AND/OR results.
module logic_pattern_sequencer
    import lps_pkg::*;
#(
    parameter int NUM_STEPS = 5,
    parameter int DWELL_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    input  logic                  and_i,
    input  logic                  or_i,
    output logic                  a_o,
    output logic                  b_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ERR_STEP_W-1:0] err_step_o
);

    localparam logic [ERR_STEP_W-1:0] LAST_STEP = ERR_STEP_W'(NUM_STEPS - 1);

    state_e                state_q, state_d;
    logic [ERR_STEP_W-1:0] step_q, step_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  a_q, a_d, b_q, b_d;
    logic                  err_q, err_d;
    logic [ERR_STEP_W-1:0] err_step_q, err_step_d;
    logic                  tmr_load, tmr_en, tmr_expire;
    logic                  busy, mismatch;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .dwell_i  (dwell_q),
        .expire_o (tmr_expire)
    );

    assign busy     = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
    assign mismatch = (and_i != (a_q & b_q)) || (or_i != (a_q | b_q));

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        err_step_d = err_step_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = DRIVE;
                    dwell_d    = dwell_i;
                    step_d     = '0;
                    err_d      = 1'b0;
                    err_step_d = '0;
                end
            end
            DRIVE: begin
                {a_d, b_d} = gray2(step_q[1:0]);
                tmr_load   = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                tmr_en = 1'b1;
                if (tmr_expire) state_d = CHECK;
            end
            CHECK: begin
                // only the first failing step is recorded
                if (mismatch && !err_q) begin
                    err_d      = 1'b1;
                    err_step_d = step_q;
                end
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + ERR_STEP_W'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort discards the step in flight but keeps any recorded error
        if (abort_i && busy) begin
            state_d    = IDLE;
            a_d        = 1'b0;
            b_d        = 1'b0;
            err_d      = err_q;
            err_step_d = err_step_q;
            tmr_load   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            dwell_q    <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            err_q      <= 1'b0;
            err_step_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_q      <= err_d;
            err_step_q <= err_step_d;
        end
    end

    assign a_o        = a_q;
    assign b_o        = b_q;
    assign busy_o     = busy;
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;
    assign err_step_o = err_step_q;

endmodule
